event_logger: RTL and testbench

- Hardware logging block that captures severity-tagged message words from a producer.
- Each accepted entry is timestamped with a free-running cycle counter and stored in a circular buffer.
- Entries are exposed to a consumer through a first-word-fall-through (FWFT) read port.
- Tracks dropped entries and raises a sticky fatal flag. Used as the on-chip sink for assertion/trace events in the CPU.

---
 rtl/logger_pkg.sv | 22 ++
 rtl/log_fifo.sv | 60 ++++++
 rtl/event_logger.sv | 83 ++++++++
 tb/tb_event_logger.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/logger_pkg.sv
// Shared types and default sizing for the event logger.
package logger_pkg;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_MSG_W  = 64;
    localparam int DEF_TS_W   = 32;
    localparam int DEF_DROP_W = 16;

    typedef enum logic [1:0] {
        SEV_INFO  = 2'd0,
        SEV_WARN  = 2'd1,
        SEV_ERROR = 2'd2,
        SEV_FATAL = 2'd3
    } sev_e;

    typedef struct packed {
        sev_e                 sev;
        logic [DEF_MSG_W-1:0] msg;
        logic [DEF_TS_W-1:0]  ts;
    } log_entry_t;

endpackage

// File: rtl/log_fifo.sv
// Generic first-word-fall-through ring buffer with flush.
// Flush beats push and pop in the same cycle; an empty head reads as zero.
module log_fifo
    import logger_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    parameter type T     = log_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  T                           din,
    output T                           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    T                mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == DEPTH[$clog2(DEPTH+1)-1:0]);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the push needs, so a full buffer can still take one.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/event_logger.sv
// Timestamped severity log sink: ring buffer plus drop counter and sticky fatal flag.
module event_logger
    import logger_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int MSG_W  = DEF_MSG_W,
    parameter int TS_W   = DEF_TS_W,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       log_valid,
    input  logic [1:0]                 log_sev,
    input  logic [MSG_W-1:0]           log_msg,
    output logic                       log_ready,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [1:0]                 rd_sev,
    output logic [MSG_W-1:0]           rd_msg,
    output logic [TS_W-1:0]            rd_ts,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       fatal,
    input  logic                       clear
);

    typedef struct packed {
        sev_e             sev;
        logic [MSG_W-1:0] msg;
        logic [TS_W-1:0]  ts;
    } entry_t;

    logic [TS_W-1:0] ts;
    entry_t          wr_entry;
    entry_t          head;
    logic            full;
    logic            empty;
    logic            rd_fire;
    logic            accept;
    logic            dropped;

    assign rd_valid  = ~empty;
    assign rd_fire   = rd_en & rd_valid;
    assign log_ready = ~full | rd_fire;
    // A clearing cycle neither stores nor counts the offered entry.
    assign accept    = log_valid &  log_ready & ~clear;
    assign dropped   = log_valid & ~log_ready & ~clear;

    assign wr_entry = '{sev: sev_e'(log_sev), msg: log_msg, ts: ts};
    assign rd_sev   = head.sev;
    assign rd_msg   = head.msg;
    assign rd_ts    = head.ts;

    log_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (rd_en),
        .flush (clear),
        .din   (wr_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          drop_cnt <= '0;
        else if (clear)                      drop_cnt <= '0;
        else if (dropped && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 fatal <= 1'b0;
        else if (log_valid && log_sev == SEV_FATAL) fatal <= 1'b1;
    end

endmodule

// File: tb/tb_event_logger.sv
// Bench for event_logger: directed scenarios plus random traffic against a queue model.
module tb_event_logger;
    import logger_pkg::*;

    localparam int DEPTH  = 16;
    localparam int MSG_W  = 64;
    localparam int TS_W   = 32;
    localparam int DROP_W = 16;
    localparam int CW     = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             log_valid = 1'b0;
    logic [1:0]       log_sev = '0;
    logic [MSG_W-1:0] log_msg = '0;
    logic             log_ready;
    logic             rd_en = 1'b0;
    logic             rd_valid;
    logic [1:0]       rd_sev;
    logic [MSG_W-1:0] rd_msg;
    logic [TS_W-1:0]  rd_ts;
    logic [CW-1:0]    count;
    logic [DROP_W-1:0] drop_cnt;
    logic             fatal;
    logic             clear = 1'b0;

    event_logger #(.DEPTH(DEPTH), .MSG_W(MSG_W), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst_n(rst_n), .log_valid(log_valid), .log_sev(log_sev),
        .log_msg(log_msg), .log_ready(log_ready), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_sev(rd_sev), .rd_msg(rd_msg), .rd_ts(rd_ts), .count(count),
        .drop_cnt(drop_cnt), .fatal(fatal), .clear(clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       sev;
        logic [MSG_W-1:0] msg;
        logic [TS_W-1:0]  ts;
    } ent_t;

    ent_t            q[$];
    logic [TS_W-1:0] m_ts = '0;
    int              m_drop = 0;
    bit              m_fatal = 1'b0;
    int              vectors = 0;
    int              errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ent_t h;
        bit   exp_ready;
        h = '{default: '0};
        if (q.size() > 0) h = q[0];
        exp_ready = (q.size() < DEPTH) || (rd_en && q.size() > 0);
        chk("rd_valid", rd_valid, q.size() > 0);
        chk("rd_sev", rd_sev, h.sev);
        chk("rd_msg", rd_msg, h.msg);
        chk("rd_ts", rd_ts, h.ts);
        chk("count", count, q.size());
        chk("drop_cnt", drop_cnt, m_drop);
        chk("fatal", fatal, m_fatal);
        chk("log_ready", log_ready, exp_ready);
    endtask

    // Drive one cycle: apply inputs at negedge, check, then advance the model at posedge.
    task automatic step(input bit v, input logic [1:0] s, input logic [MSG_W-1:0] m,
                        input bit r, input bit c);
        bit   rdy;
        ent_t e;
        @(negedge clk);
        log_valid = v; log_sev = s; log_msg = m; rd_en = r; clear = c;
        #1 check_all();
        @(posedge clk);
        rdy = (q.size() < DEPTH) || (r && q.size() > 0);
        if (c) begin
            q.delete();
            m_drop = 0;
        end else begin
            if (r && q.size() > 0) void'(q.pop_front());
            if (v && rdy) begin
                e.sev = s; e.msg = m; e.ts = m_ts;
                q.push_back(e);
            end else if (v && m_drop < (2**DROP_W - 1)) begin
                m_drop++;
            end
        end
        if (v && s == 2'd3) m_fatal = 1'b1;
        m_ts = m_ts + 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 2'd0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [MSG_W-1:0] rnd_msg();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #3;
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (5) idle();

        // Three entries stamped 10, 11, 12, then drained in order.
        while (m_ts != 32'd10) idle();
        step(1'b1, 2'd0, 64'hA, 1'b0, 1'b0);
        step(1'b1, 2'd0, 64'hB, 1'b0, 1'b0);
        step(1'b1, 2'd0, 64'hC, 1'b0, 1'b0);
        #1 chk("head_a_msg", rd_msg, 64'hA);
        chk("head_a_ts", rd_ts, 32'd10);
        step(1'b0, 2'd0, '0, 1'b1, 1'b0);
        #1 chk("head_b_msg", rd_msg, 64'hB);
        chk("head_b_ts", rd_ts, 32'd11);
        step(1'b0, 2'd0, '0, 1'b1, 1'b0);
        #1 chk("head_c_msg", rd_msg, 64'hC);
        chk("head_c_ts", rd_ts, 32'd12);
        step(1'b0, 2'd0, '0, 1'b1, 1'b0);
        #1 chk("drained", rd_valid, 0);

        // Fill, overflow by three, then write+pop while full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 2'($urandom_range(0, 2)), rnd_msg(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd1, rnd_msg(), 1'b0, 1'b0);
        #1 chk("full_ready", log_ready, 0);
        chk("full_count", count, DEPTH);
        chk("full_drops", drop_cnt, 3);
        step(1'b1, 2'd2, rnd_msg(), 1'b1, 1'b0);
        #1 chk("wr_rd_full_count", count, DEPTH);
        chk("wr_rd_full_drops", drop_cnt, 3);
        step(1'b1, 2'd3, rnd_msg(), 1'b0, 1'b0);
        #1 chk("fatal_drop", drop_cnt, 4);
        chk("fatal_set", fatal, 1);
        repeat (2) step(1'b0, 2'd0, '0, 1'b1, 1'b0);
        step(1'b1, 2'd3, rnd_msg(), 1'b1, 1'b1);
        #1 chk("clear_count", count, 0);
        chk("clear_drops", drop_cnt, 0);
        chk("clear_fatal", fatal, 1);

        // Streaming across pointer wrap with a pop every cycle.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 2'($urandom_range(0, 2)), rnd_msg(), i > 0, 1'b0);
            #1 chk("stream_count_le1", count <= 1, 1);
        end
        step(1'b0, 2'd0, '0, 1'b1, 1'b0);

        // Random mix including occasional clears.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rnd_msg(),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);

        // Asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 6; i++) step(1'b1, 2'($urandom_range(0, 3)), rnd_msg(), 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_rd_valid", rd_valid, 0);
        chk("async_rd_msg", rd_msg, 0);
        chk("async_drops", drop_cnt, 0);
        chk("async_fatal", fatal, 0);
        log_valid = 1'b0; rd_en = 1'b0; clear = 1'b0;
        q.delete(); m_drop = 0; m_fatal = 1'b0; m_ts = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 2'd0, 64'h77, 1'b0, 1'b0);
        #1 chk("ts_restart", rd_ts, 0);
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 1) != 0, 2'($urandom_range(0, 2)), rnd_msg(),
                 $urandom_range(0, 1) != 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
